ft232r_rsp_arb: RTL and testbench

Round-robin arbiter sharing the single FT232R response (FPGA-to-host) byte channel among P_N internal requesters. Each requester presents a byte on a 4-phase req/ack handshake; the arbiter forwards one byte at a time to the downstream `rsp_req`/`rsp_ack`/`rsp_data` port of the FT232R handshake adapter. A per-requester lock keeps a grant across consecutive bytes so multi-byte packets are not interleaved. A watchdog releases the channel if the downstream side never answers.

---
 rtl/ft232r_rsp_arb.sv | 187 ++++++++++++++++++
 tb/tb_ft232r_rsp_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ft232r_rsp_arb.sv
// Round-robin arbiter sharing the FT232R response byte channel among P_N
// 4-phase requesters, with per-requester grant lock and a downstream watchdog.
module ft232r_rsp_arb #(
  parameter int P_N               = 4,
  parameter int P_TIMEOUT_CNT_MAX = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [P_N-1:0]   up_req,
  input  logic [P_N-1:0]   up_lock,
  input  logic [8*P_N-1:0] up_data,
  output logic [P_N-1:0]   up_ack,
  output logic             dn_req,
  output logic [7:0]       dn_data,
  input  logic             dn_ack,
  output logic [P_N-1:0]   grant,
  output logic             busy,
  output logic             timeout_err
);

  localparam int PW = (P_N > 1) ? $clog2(P_N) : 1;
  localparam int CW = (P_TIMEOUT_CNT_MAX > 0) ? $clog2(P_TIMEOUT_CNT_MAX + 1) : 1;
  localparam bit WD_EN = (P_TIMEOUT_CNT_MAX != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT_CNT_MAX - 1);
  localparam logic [PW-1:0] PTR_RST  = PW'(P_N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DN_REQ = 3'd1,
    S_DN_REL = 3'd2,
    S_UP_ACK = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [P_N-1:0]   grant_q, grant_d;
  logic [P_N-1:0]   up_ack_q, up_ack_d;
  logic             dn_req_q, dn_req_d;
  logic [7:0]       dn_data_q, dn_data_d;
  logic             to_q, to_d;
  logic             busy_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PW-1:0]    pick_s;
  logic [PW-1:0]    cand_s;
  logic             found_s;
  logic             wd_hit_s;

  function automatic logic [7:0] sel_byte(input logic [8*P_N-1:0] d,
                                          input logic [PW-1:0]    idx);
    return d[{idx, 3'b000} +: 8];
  endfunction

  // Fires on the edge where the wait counter would reach its limit.
  assign wd_hit_s = WD_EN && (cnt_q == CNT_LAST);

  // First pending requester after the last owner, wrapping modulo P_N.
  always_comb begin
    pick_s  = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int off = 1; off <= P_N; off++) begin
      cand_s = PW'((int'(ptr_q) + off) % P_N);
      if (!found_s && up_req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    up_ack_d  = up_ack_q;
    dn_req_d  = dn_req_q;
    dn_data_d = dn_data_q;
    cnt_d     = cnt_q;
    to_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          gidx_d    = pick_s;
          grant_d   = P_N'(1) << pick_s;
          dn_data_d = sel_byte(up_data, pick_s);
          dn_req_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_DN_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DN_REQ, S_DN_REL: begin
        cnt_d = cnt_q + CW'(1);
        if (wd_hit_s) begin
          // Abort still releases the requester so it never stalls.
          dn_req_d = 1'b0;
          to_d     = 1'b1;
          up_ack_d = grant_q;
          state_d  = S_UP_ACK;
        end else if (state_q == S_DN_REQ && dn_ack) begin
          dn_req_d = 1'b0;
          state_d  = S_DN_REL;
        end else if (state_q == S_DN_REL && !dn_ack) begin
          up_ack_d = grant_q;
          state_d  = S_UP_ACK;
        end else begin
          state_d = state_q;
        end
      end
      S_UP_ACK: begin
        if (!up_req[gidx_q]) begin
          up_ack_d = '0;
          ptr_d    = gidx_q;
          if (up_lock[gidx_q]) begin
            state_d = S_HOLD;
          end else begin
            grant_d = '0;
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_UP_ACK;
        end
      end
      S_HOLD: begin
        if (up_req[gidx_q]) begin
          dn_data_d = sel_byte(up_data, gidx_q);
          dn_req_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_DN_REQ;
        end else if (!up_lock[gidx_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        grant_d  = '0;
        up_ack_d = '0;
        dn_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_RST;
      gidx_q    <= '0;
      grant_q   <= '0;
      up_ack_q  <= '0;
      dn_req_q  <= 1'b0;
      dn_data_q <= 8'h00;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      up_ack_q  <= up_ack_d;
      dn_req_q  <= dn_req_d;
      dn_data_q <= dn_data_d;
      to_q      <= to_d;
      busy_q    <= (state_d != S_IDLE);
      cnt_q     <= cnt_d;
    end
  end

  assign up_ack      = up_ack_q;
  assign dn_req      = dn_req_q;
  assign dn_data     = dn_data_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_ft232r_rsp_arb.sv
// Scoreboard bench for ft232r_rsp_arb: stimulus pushes expected grant/byte
// pairs, a negedge monitor pops and compares on every dn_req rise.
module tb_ft232r_rsp_arb;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   up_req, up_lock, up_ack, grant;
  logic [8*N-1:0] up_data;
  logic           dn_req, dn_ack, busy, timeout_err;
  logic [7:0]     dn_data;

  typedef struct packed {
    logic [N-1:0] g;
    logic [7:0]   d;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_mode = 1;
  int ack_delay = 3;
  int ack_hold = 1;
  int exp_dur = 4;
  int to_seen = 0;
  int to_exp = 0;

  logic         m_pdr;
  logic [N-1:0] m_pua;
  logic [N-1:0] m_cur_g;
  int           m_rise;
  int           m_to_chk;
  exp_t         m_e;

  ft232r_rsp_arb #(.P_N(N), .P_TIMEOUT_CNT_MAX(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req(up_req), .up_lock(up_lock), .up_data(up_data), .up_ack(up_ack),
    .dn_req(dn_req), .dn_data(dn_data), .dn_ack(dn_ack),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic serve(input int i, input logic [7:0] d, input logic lk);
    int w;
    up_data[8*i +: 8] = d;
    up_lock[i] = lk;
    up_req[i]  = 1'b1;
    w = 0;
    while (!up_ack[i] && w < 200) begin @(posedge clk); #1; w++; end
    chk("up_ack_seen", 32'(up_ack[i]), 32'h1);
    up_req[i] = 1'b0;
    w = 0;
    while (up_ack[i] && w < 200) begin @(posedge clk); #1; w++; end
    chk("up_ack_release", 32'(up_ack[i]), 32'h0);
  endtask

  // Downstream adapter model: ack after ack_delay clocks, hold ack_hold clocks.
  initial begin
    dn_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (dn_req && ack_mode != 0) begin
        repeat (ack_delay) @(posedge clk);
        #1 dn_ack = 1'b1;
        repeat (ack_hold) @(posedge clk);
        #1 dn_ack = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops plus handshake timing checks.
  initial begin
    m_pdr = 1'b0; m_pua = '0; m_cur_g = '0; m_rise = 0; m_to_chk = 0;
    forever begin
      @(negedge clk);
      if (m_to_chk != 0) begin
        chk("timeout_err_width", 32'(timeout_err), 32'h0);
        m_to_chk = 0;
      end
      if (dn_req && !m_pdr) begin
        chk("sb_pending", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          m_cur_g = m_e.g;
          chk("grant", 32'(grant), 32'(m_e.g));
          chk("dn_data", 32'(dn_data), 32'(m_e.d));
        end
        m_rise = cyc;
      end
      if (!dn_req && m_pdr && exp_dur != 0)
        chk("dn_req_width", 32'(cyc - m_rise), 32'(exp_dur));
      if (timeout_err) begin
        to_seen++;
        chk("timeout_expected", 32'(to_exp), 32'h1);
        chk("timeout_latency", 32'(cyc - m_rise), 32'(TO));
        chk("timeout_up_ack", 32'(up_ack), 32'(m_cur_g));
        m_to_chk = 1;
      end
      if ((up_ack & ~m_pua) != '0) begin
        chk("up_ack_owner", 32'(up_ack), 32'(m_cur_g));
        chk("up_ack_dn_ack_low", 32'(dn_ack), 32'h0);
      end
      m_pdr = dn_req;
      m_pua = up_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench hung");
  end

  initial begin
    int w;
    rst_n = 1'b0; up_req = '0; up_lock = '0; up_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dn_req", 32'(dn_req), 32'h0);
    chk("rst_dn_data", 32'(dn_data), 32'h0);
    chk("rst_up_ack", 32'(up_ack), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin: order 0,1,2,3,0 from the reset pointer.
    sb.push_back({4'b0001, 8'h10});
    sb.push_back({4'b0010, 8'h21});
    sb.push_back({4'b0100, 8'h32});
    sb.push_back({4'b1000, 8'h43});
    sb.push_back({4'b0001, 8'h50});
    fork
      begin serve(0, 8'h10, 1'b0); serve(0, 8'h50, 1'b0); end
      serve(1, 8'h21, 1'b0);
      serve(2, 8'h32, 1'b0);
      serve(3, 8'h43, 1'b0);
    join

    // Single byte.
    sb.push_back({4'b0100, 8'hA5});
    serve(2, 8'hA5, 1'b0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_grant", 32'(grant), 32'h0);

    // Lock: requester 1 keeps the channel for three bytes.
    sb.push_back({4'b0010, 8'h11});
    sb.push_back({4'b0010, 8'h22});
    sb.push_back({4'b0010, 8'h33});
    sb.push_back({4'b1000, 8'h44});
    fork
      begin
        serve(1, 8'h11, 1'b1);
        serve(1, 8'h22, 1'b1);
        serve(1, 8'h33, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_grant", 32'(grant), 32'h2);
        chk("hold_no_ack3", 32'(up_ack[3]), 32'h0);
        up_lock[1] = 1'b0;
      end
      begin
        w = 0;
        while (!grant[1] && w < 100) begin @(negedge clk); w++; end
        chk("lock_grant1_seen", 32'(grant[1]), 32'h1);
        serve(3, 8'h44, 1'b0);
      end
    join

    // Level ack held 10 cycles.
    ack_delay = 1; ack_hold = 10; exp_dur = 2;
    sb.push_back({4'b0001, 8'h5A});
    serve(0, 8'h5A, 1'b0);
    ack_delay = 3; ack_hold = 1; exp_dur = 4;

    // Watchdog abort, then normal service.
    ack_mode = 0; exp_dur = TO; to_exp = 1;
    sb.push_back({4'b0100, 8'hC3});
    serve(2, 8'hC3, 1'b0);
    to_exp = 0;
    chk("timeout_count", 32'(to_seen), 32'h1);
    ack_mode = 1; exp_dur = 4;
    sb.push_back({4'b1000, 8'h3C});
    serve(3, 8'h3C, 1'b0);

    // Asynchronous reset mid-transfer.
    ack_mode = 0; exp_dur = 0;
    sb.push_back({4'b0010, 8'h77});
    up_data[15:8] = 8'h77;
    up_req[1] = 1'b1;
    w = 0;
    while (!dn_req && w < 100) begin @(negedge clk); w++; end
    chk("rst_mid_dn_req_seen", 32'(dn_req), 32'h1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("amid_dn_req", 32'(dn_req), 32'h0);
    chk("amid_dn_data", 32'(dn_data), 32'h0);
    chk("amid_up_ack", 32'(up_ack), 32'h0);
    chk("amid_grant", 32'(grant), 32'h0);
    chk("amid_busy", 32'(busy), 32'h0);
    chk("amid_timeout", 32'(timeout_err), 32'h0);
    up_req = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    ack_mode = 1; exp_dur = 4;
    sb.push_back({4'b0001, 8'h0A});
    sb.push_back({4'b1000, 8'hB3});
    fork
      serve(0, 8'h0A, 1'b0);
      serve(3, 8'hB3, 1'b0);
    join

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
